// File: rtl/bcd_sched_pkg.sv
// bcd_sched_pkg: shared state encoding, digit geometry and defaults for bcd_scheduler.
package bcd_sched_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        WAIT = ST_WAIT,
        DONE = ST_DONE
    } state_t;

    localparam int DIG_W       = 4;
    localparam int DIG_N       = 5;
    localparam int RES_W       = DIG_W * DIG_N;
    localparam int DEF_TIMEOUT = 70000;

    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bcd_scheduler_rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin grant, search starts just after ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] grant
);

    // Walk from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        grant = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ])
                grant = NUM_REQ'(1) << ((int'(ptr) + k) % NUM_REQ);
        end
    end

endmodule

// File: rtl/bcd_scheduler.sv
// bcd_scheduler: round-robin sharing of one bcd converter among NUM_REQ requesters.
// Optional WAIT watchdog and timeout_err port enabled by BCD_SCHED_TIMEOUT_EN.
module bcd_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_number,
    output logic [NUM_REQ-1:0]     done,
    output logic [RES_W-1:0]       res_digits,
    output logic [2:0]             grant_id,
    output logic                   busy,
`ifdef BCD_SCHED_TIMEOUT_EN
    output logic                   timeout_err,
`endif
    output logic                   bcd_load,
    output logic [15:0]            bcd_number,
    input  logic                   bcd_ready,
    input  logic [DIG_W-1:0]       bcd_dig_1,
    input  logic [DIG_W-1:0]       bcd_dig_2,
    input  logic [DIG_W-1:0]       bcd_dig_3,
    input  logic [DIG_W-1:0]       bcd_dig_4,
    input  logic [DIG_W-1:0]       bcd_dig_5
);

    state_t               state;
    logic [2:0]           ptr;
    logic                 mask_last;
    logic [NUM_REQ-1:0]   req_eff;
    logic [NUM_REQ-1:0]   grant;
    logic [2:0]           win_idx;

`ifdef BCD_SCHED_TIMEOUT_EN
    logic [16:0]          wait_cnt;
`endif

    // The previous winner sits out the one IDLE cycle right after its DONE.
    assign req_eff = req & ~(mask_last ? NUM_REQ'(1) << ptr : '0);
    assign win_idx = oh_to_idx(8'(grant));

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_eff),
        .ptr   (ptr),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            done       <= '0;
            bcd_load   <= 1'b0;
            busy       <= 1'b0;
            res_digits <= '0;
            grant_id   <= '0;
            bcd_number <= '0;
            ptr        <= '0;
            mask_last  <= 1'b0;
`ifdef BCD_SCHED_TIMEOUT_EN
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            done     <= '0;
            bcd_load <= 1'b0;
            unique case (state)
                IDLE: begin
                    mask_last <= 1'b0;
                    if (bcd_ready && |req_eff) begin
                        grant_id   <= win_idx;
                        bcd_number <= req_number[16*win_idx +: 16];
                        bcd_load   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LOAD;
`ifdef BCD_SCHED_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end
                end
                LOAD: state <= WAIT;
                WAIT: begin
                    if (bcd_ready) begin
                        res_digits <= {bcd_dig_5, bcd_dig_4, bcd_dig_3, bcd_dig_2, bcd_dig_1};
                        done       <= NUM_REQ'(1) << grant_id;
                        state      <= DONE;
                    end
`ifdef BCD_SCHED_TIMEOUT_EN
                    else if (wait_cnt == 17'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        res_digits  <= {RES_W{1'b1}};
                        done        <= NUM_REQ'(1) << grant_id;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 17'd1;
                    end
`endif
                end
                DONE: begin
                    ptr       <= grant_id;
                    mask_last <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_scheduler.sv
// tb_bcd_scheduler: randomized and directed checks of bcd_scheduler against a transaction-level model,
// with a cycle-counting bcd stand-in; BCD_SCHED_TIMEOUT_EN adds the watchdog scenario.
module tb_bcd_scheduler;

    localparam int N = 4;
`ifdef BCD_SCHED_TIMEOUT_EN
    localparam int TO = 50;
    localparam logic [19:0] MAX_DIG = 20'hFFFFF;
`else
    localparam int TO = 0;
    localparam logic [19:0] MAX_DIG = 20'h65535;
`endif

    logic clk = 0, reset = 0;
    logic [N-1:0] req = '0;
    logic [16*N-1:0] req_number = '0;
    logic [N-1:0] done;
    logic [19:0] res_digits;
    logic [2:0] grant_id;
    logic busy, bcd_load, bcd_ready;
    logic [15:0] bcd_number;
    logic [3:0] d1, d2, d3, d4, d5;
`ifdef BCD_SCHED_TIMEOUT_EN
    logic timeout_err;
`endif

    bcd_scheduler #(.NUM_REQ(N)
`ifdef BCD_SCHED_TIMEOUT_EN
        , .TIMEOUT(TO)
`endif
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_number(req_number),
        .done(done), .res_digits(res_digits), .grant_id(grant_id), .busy(busy),
`ifdef BCD_SCHED_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .bcd_load(bcd_load), .bcd_number(bcd_number), .bcd_ready(bcd_ready),
        .bcd_dig_1(d1), .bcd_dig_2(d2), .bcd_dig_3(d3), .bcd_dig_4(d4), .bcd_dig_5(d5)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input int n);
        logic [19:0] r;
        int v;
        v = n;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // bcd stand-in: busy for n cycles after a load, digits settle when it returns to idle
    int rem = 0;
    logic [15:0] tgt = '0;
    logic [19:0] bdig = '0;
    bit stall = 0;
    assign bcd_ready = (rem == 0) && !stall;
    assign {d5, d4, d3, d2, d1} = bdig;
    always @(posedge clk) begin
        if (bcd_load && rem == 0) begin
            rem  <= int'(bcd_number);
            tgt  <= bcd_number;
            bdig <= '0;
        end else if (rem != 0) begin
            rem <= rem - 1;
            if (rem == 1) bdig <= to_bcd(int'(tgt));
        end
    end

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // transaction-level reference model
    bit m_free = 1, m_mask = 0, m_to = 0, m_err = 0, force_to = 0, auto_en = 0;
    int m_last = 0, m_win = 0, m_done_at = -1, m_load_at = -1;
    logic [15:0] m_num = '0;
    logic [19:0] m_dig = '0;
    int cyc = 0, last_done_cyc = -1;
    int drop_at[N];
    int ndone[N];
    int q[$];

    task automatic model_edge();
        logic [N-1:0] eff;
        if (!reset) begin
            m_free = 1; m_mask = 0; m_last = 0; m_win = 0; m_dig = '0; m_err = 0;
            m_done_at = -1; m_load_at = -1;
        end else if (m_free) begin
            eff = req & ~(m_mask ? N'(1) << m_last : N'(0));
            m_mask = 0;
            if (bcd_ready && eff != 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (eff[(m_last + k) % N]) begin
                        m_win = (m_last + k) % N;
                        break;
                    end
                end
                m_num = req_number[16*m_win +: 16];
                m_to = force_to;
`ifdef BCD_SCHED_TIMEOUT_EN
                if (int'(m_num) >= TO) m_to = 1;
`endif
                m_free = 0;
                m_load_at = cyc + 1;
                m_done_at = m_to ? cyc + TO + 2 : cyc + int'(m_num) + 3;
            end
        end else if (cyc == m_done_at) begin
            m_free = 1; m_mask = 1; m_last = m_win;
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        cyc++;
        if (cyc == m_done_at) begin
            m_dig = m_to ? 20'hFFFFF : to_bcd(int'(m_num));
            if (m_to) m_err = 1;
        end
        check("done", 32'(done), (cyc == m_done_at) ? 32'(1) << m_win : 32'd0);
        check("busy", 32'(busy), 32'(!m_free));
        check("bcd_load", 32'(bcd_load), 32'(cyc == m_load_at));
        check("grant_id", 32'(grant_id), 32'(m_win));
        check("res_digits", 32'(res_digits), 32'(m_dig));
        if (cyc == m_load_at) check("bcd_number", 32'(bcd_number), 32'(m_num));
`ifdef BCD_SCHED_TIMEOUT_EN
        check("timeout_err", 32'(timeout_err), 32'(m_err));
`endif
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                q.push_back(i);
                ndone[i]++;
                last_done_cyc = cyc;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (drop_at[i] == cyc) req[i] = 1'b0;
            else if (auto_en && !req[i] && drop_at[i] < cyc && $urandom_range(0, 7) == 0) begin
                req[i] = 1'b1;
                req_number[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 150));
            end
        end
        if (cyc == m_done_at) drop_at[m_win] = cyc + 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic until_q(input int sz, input int budget);
        int k;
        k = 0;
        while (q.size() < sz && k < budget) begin
            step();
            k++;
        end
        check("wait_bound", 32'(q.size()), 32'(sz));
    endtask

    task automatic raise(input int i, input int n);
        req[i] = 1'b1;
        req_number[16*i +: 16] = 16'(n);
    endtask

    function automatic int lat(input int n);
        return (TO != 0 && n >= TO) ? TO + 2 : n + 3;
    endfunction

    initial begin
        int s, nd;
        for (int i = 0; i < N; i++) begin
            drop_at[i] = -1;
            ndone[i] = 0;
        end
        @(negedge clk);
        run(3);
        check("rst_bcd_number", 32'(bcd_number), 32'd0);
        reset = 1;

        // single requester
        raise(0, 1234); s = cyc;
        until_q(1, 2000);
        check("s1_latency", 32'(last_done_cyc - s), 32'(lat(1234)));
        run(10);
        check("s1_pulses", 32'(ndone[0]), 32'd1);

        // zero operand
        raise(2, 0); s = cyc;
        until_q(2, 2000);
`ifndef BCD_SCHED_TIMEOUT_EN
        check("s2_latency", 32'(last_done_cyc - s), 32'd3);
`endif
        check("s2_digits", 32'(res_digits), 32'd0);
        run(5);

        // make requester 3 the last winner, then full contention
        raise(3, 3);
        until_q(3, 2000);
        run(5);
        for (int i = 0; i < N; i++) raise(i, 5 + i);
        until_q(7, 2000);
        for (int i = 0; i < N; i++) check("s3_order", 32'(q[3 + i]), 32'(i));
        run(5);

        // fairness: requester 0 keeps requesting after being served
        raise(0, 2); raise(1, 2);
        until_q(8, 2000);
        check("s4_first", 32'(q[7]), 32'd0);
        drop_at[0] = -1;
        until_q(10, 2000);
        check("s4_second", 32'(q[8]), 32'd1);
        check("s4_third", 32'(q[9]), 32'd0);
        run(5);

        // reset in the middle of a conversion
        raise(1, 3000); s = cyc;
        run(100);
        reset = 0;
        req[1] = 1'b0;
        step();
        reset = 1;
        nd = q.size();
        raise(2, 7);
        until_q(nd + 1, 3100);
        check("s5_winner", 32'(q[nd]), 32'd2);
`ifndef BCD_SCHED_TIMEOUT_EN
        check("s5_latency", 32'(last_done_cyc - s), 32'd3012);
`endif
        check("s5_digits", 32'(res_digits), 32'h7);
        run(5);

`ifdef BCD_SCHED_TIMEOUT_EN
        // watchdog with bcd_ready held low
        raise(0, 5); s = cyc; force_to = 1;
        step();
        force_to = 0; stall = 1;
        nd = q.size();
        until_q(nd + 1, 100);
        check("s6_latency", 32'(last_done_cyc - s), 32'd52);
        check("s6_err", 32'(timeout_err), 32'd1);
        check("s6_digits", 32'(res_digits), 32'hFFFFF);
        stall = 0;
        run(5);
`endif

        // maximum operand
        nd = q.size();
        raise(3, 65535);
        until_q(nd + 1, 65600);
        check("max_digits", 32'(res_digits), 32'(MAX_DIG));
        run(5);

        // randomized traffic, then drain
        auto_en = 1;
        run(4000);
        auto_en = 0;
        run(1000);
        check("drain_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
